// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory-wait timeout and retire counter
// Optional feature: define MC_BNE_EN to decode opcode 05 (bne) as a branch with branch_ne=1.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IMMEX  = 4'd9;
    localparam logic [3:0] S_IMMWB  = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_FAULT  = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int               WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [3:0]        state_q, state_d, cur_state;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic              timed_out;
    logic              in_wait;

    always_comb begin
        state_d   = state_q;
        timed_out = !mem_ready && (wait_q == WAIT_LAST);
        case (state_q)
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timed_out) state_d = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                state_d = S_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
                    OP_LW, OP_LH, OP_LHU, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:                  state_d = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:                  state_d = S_BRANCH;
`endif
                    OP_JUMP:                 state_d = S_JUMP;
                    default:                 state_d = S_FAULT;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)      state_d = S_MEMWB;
                else if (timed_out) state_d = S_FAULT;
            end
            S_MEMWR: begin
                if (mem_ready)      state_d = S_FETCH;
                else if (timed_out) state_d = S_FAULT;
            end
            S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_EXEC:  state_d = S_ALUWB;
            S_IMMEX: state_d = S_IMMWB;
            default: state_d = S_FAULT;
        endcase
    end

    // The counter only survives while a wait state holds itself; any transition clears it.
    always_comb begin
        in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        wait_d  = (in_wait && (state_d == state_q)) ? wait_q + WAIT_W'(1) : '0;
        // Only the final state of an instruction ever moves into FETCH.
        retire_d = retire_q;
        if ((state_q != S_FETCH) && (state_d == S_FETCH))
            retire_d = retire_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_q   <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
        end
    end

    assign cur_state    = reset ? S_FETCH : state_q;
    assign state        = cur_state;
    assign fault        = (cur_state == S_FAULT);
    assign retire_count = reset ? '0 : retire_q;

`ifdef MC_BNE_EN
    assign branch_ne = (cur_state == S_BRANCH) && (opcode == OP_BNE);
`else
    assign branch_ne = 1'b0;
`endif

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready && !reset;
                pc_write  = mem_ready && !reset;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
            end
            S_IMMWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 TIMEOUT, 16, maximum consecutive cycles a memory state SHALL wait for mem_ready before faulting (>=2).
REQ-002 CNT_W, 32, width of retire_count.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 opcode  input  6  instruction opcode field, valid from DECODE onward.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-007 pc_write  output  1  unconditional PC load.
REQ-008 pc_write_cond  output  1  PC load qualified externally by ALU zero.
REQ-009 branch_ne  output  1  invert zero qualification (bne).
REQ-010 i_or_d  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-011 mem_read / mem_write / ir_write  output  1 each  memory read, memory write, IR load.
REQ-012 mem_to_reg / reg_dst / reg_write  output  1 each  writeback source, rd-vs-rt select, register-file write.
REQ-013 alu_src_a  output  1  0 PC, 1 register A.
REQ-014 alu_src_b  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-015 alu_op  output  2  00 add, 01 sub, 10 funct, 11 logic-imm by opcode.
REQ-016 pc_source  output  2  00 ALU, 01 ALUOut, 10 jump target.
REQ-017 state  output  4  current state encoding; fault output 1 sticky fault; retire_count output CNT_W retired instructions.

Function
REQ-018 States/encodings SHALL be FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, FAULT 15; any output not listed per state SHALL be 0.
REQ-019 FETCH: mem_read=1, alu_src_b=01; ir_write=1 and pc_write=1 only in the cycle mem_ready=1, which also moves to DECODE; otherwise hold.
REQ-020 DECODE: alu_src_b=11; one cycle, then opcode 00->EXEC; 08,0C,0D->IMMEX; 23,21,25,2B->MEMADR; 04->BRANCH; 02->JUMP; any other->FAULT.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10; next MEMWR if opcode 2B, else MEMRD.
REQ-022 MEMRD: mem_read=1, i_or_d=1; to MEMWB on mem_ready. MEMWB: reg_write=1, mem_to_reg=1; to FETCH.
REQ-023 MEMWR: mem_write=1, i_or_d=1; to FETCH on mem_ready.
REQ-024 EXEC: alu_src_a=1, alu_op=10; to ALUWB. ALUWB: reg_dst=1, reg_write=1; to FETCH.
REQ-025 IMMEX: alu_src_a=1, alu_src_b=10, alu_op=00 for 08, 11 for 0C/0D; to IMMWB. IMMWB: reg_write=1; to FETCH.
REQ-026 BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01; JUMP: pc_write=1, pc_source=10; both to FETCH after one cycle.
REQ-027 Wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each cycle mem_ready=0 there; with mem_ready=0 at count TIMEOUT-1, next state SHALL be FAULT.
REQ-028 mem_ready=1 in the same cycle as count TIMEOUT-1 SHALL complete the access normally (ready wins).
REQ-029 FAULT: all control outputs 0, fault=1, held until reset; opcode and mem_ready ignored.
REQ-030 retire_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, IMMWB, BRANCH, JUMP; wraps modulo 2^CNT_W; never increments on entry to FAULT.
REQ-031 Latencies SHALL be, with zero-wait memory: R/imm 4 cycles, lw 5, sw 4, beq/jump 3.

Reset
REQ-032 reset=1 at a rising edge SHALL force state FETCH, wait counter 0, fault 0, retire_count 0, at any state including mid-access and FAULT.
REQ-033 While reset=1, outputs SHALL reflect FETCH with ir_write and pc_write forced 0.

Configuration
REQ-034 With MC_BNE_EN defined, opcode 05 SHALL decode to BRANCH with branch_ne=1 (beq keeps branch_ne=0).
REQ-035 Without MC_BNE_EN, opcode 05 SHALL go to FAULT and branch_ne SHALL be constant 0.

Verification
REQ-036 Reset, then R-type opcode 00, mem_ready=1 always -> states 0,1,6,7,0; reg_write=1 in state 7; retire_count=1 after 4 cycles.
REQ-037 lw opcode 23, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1, total 8 cycles.
REQ-038 FETCH with mem_ready stuck 0, TIMEOUT=16 -> FAULT (state 15, fault=1) after 16 cycles; reset -> FETCH, fault=0, retire_count=0.
REQ-039 Opcode 05 -> with MC_BNE_EN BRANCH, branch_ne=1, pc_write_cond=1; without, FAULT next cycle.
REQ-040 CNT_W=4, 16 back-to-back jumps (opcode 02) -> retire_count wraps 15->0; unknown opcode 3F -> FAULT, count unchanged.
